// File: rtl/uart_cmd_engine_if.sv
// Signal bundle between the serial command engine, its UART byte links and
// the downstream command unit.
interface uart_cmd_engine_if #(
  parameter int DATA_W = 32,
  parameter int RESP_W = 32
);
  localparam int LEN_W = $clog2(RESP_W/4 + 1);

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_busy;
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_done;
  logic [RESP_W-1:0] resp_data;
  logic [LEN_W-1:0]  resp_len;
  logic              rx_drop;

  modport master (
    input  rx_data, rx_valid, tx_busy, cmd_done, resp_data, resp_len,
    output tx_data, tx_start, cmd_valid, cmd_code, cmd_data, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, tx_busy, cmd_done, resp_data, resp_len,
    input  tx_data, tx_start, cmd_valid, cmd_code, cmd_data, rx_drop
  );
endinterface

// File: rtl/uart_cmd_engine.sv
// Parses "$<letter><hex>+" from the UART receiver, dispatches it over a
// valid/done handshake and streams echoes and "+<hex>" replies to the transmitter.
module uart_cmd_engine #(
  parameter int DATA_W  = 32,
  parameter int RESP_W  = 32,
  parameter int TIMEOUT = 5000000
) (
  input  logic clk,
  input  logic reset,
  uart_cmd_engine_if.master bus
);
  localparam int NIB   = RESP_W / 4;
  localparam int QN    = 4 + NIB;
  localparam int CW    = $clog2(QN + 1);
  localparam int LEN_W = $clog2(NIB + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_PLUS   = 8'h2B;

  typedef enum logic [2:0] {IDLE, EXEC, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t            state_q, state_d;
  logic [7:0]        buf_q [QN];
  logic [7:0]        buf_d [QN];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [7:0]        cmd_code_q, cmd_code_d;
  logic [DATA_W-1:0] cmd_data_q, cmd_data_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              tx_start_q, tx_start_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              rx_drop_q, rx_drop_d;

  logic [LEN_W-1:0]  len_c;
  logic [RESP_W-1:0] resp_aligned;

  function automatic logic [3:0] asc2nib(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return c[3:0];
    else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
      return c[3:0] + 4'd9;
    else
      return 4'd0;
  endfunction

  function automatic logic [7:0] nib2asc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Left-justify the requested digits so digit i always sits at a fixed slice.
  assign len_c        = (bus.resp_len > LEN_W'(NIB)) ? LEN_W'(NIB) : bus.resp_len;
  assign resp_aligned = bus.resp_data << (4 * (NIB - int'(len_c)));

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    cmd_code_d  = cmd_code_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = cmd_valid_q;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    rx_drop_d   = rx_drop_q;

    if (bus.rx_valid && state_q != IDLE) rx_drop_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == CH_DOLLAR) begin
            cmd_code_d = '0;
            cmd_data_d = '0;
            rx_drop_d  = 1'b0;
            buf_d[0]   = bus.rx_data;
            cnt_d      = CW'(1);
            state_d    = SEND;
          end else if (bus.rx_data == CH_PLUS) begin
            if (cmd_code_q >= 8'h41 && cmd_code_q <= 8'h5A) begin
              cmd_valid_d = 1'b1;
              timer_d     = TW'(TIMEOUT - 1);
              state_d     = EXEC;
            end else begin
              buf_d[0] = CH_PLUS;
              buf_d[1] = 8'h45;
              buf_d[2] = 8'h52;
              buf_d[3] = 8'h52;
              cnt_d    = CW'(4);
              state_d  = SEND;
            end
          end else begin
            buf_d[0] = bus.rx_data;
            cnt_d    = CW'(1);
            state_d  = SEND;
            if (cmd_code_q == 8'h00)
              cmd_code_d = bus.rx_data;
            else
              cmd_data_d = (cmd_data_q << 4) | DATA_W'(asc2nib(bus.rx_data));
          end
        end
      end
      EXEC: begin
        if (bus.cmd_done) begin
          cmd_valid_d = 1'b0;
          cmd_code_d  = '0;
          cmd_data_d  = '0;
          buf_d[0]    = CH_PLUS;
          for (int i = 0; i < NIB; i++)
            buf_d[i+1] = nib2asc(resp_aligned[RESP_W-1-4*i -: 4]);
          cnt_d   = CW'(len_c) + CW'(1);
          state_d = SEND;
        end else if (timer_q == '0) begin
          cmd_valid_d = 1'b0;
          cmd_code_d  = '0;
          cmd_data_d  = '0;
          buf_d[0]    = CH_PLUS;
          buf_d[1]    = 8'h54;
          buf_d[2]    = 8'h4F;
          cnt_d       = CW'(3);
          state_d     = SEND;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      SEND: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = buf_q[0];
          for (int i = 0; i < QN - 1; i++) buf_d[i] = buf_q[i+1];
          buf_d[QN-1] = '0;
          cnt_d       = cnt_q - CW'(1);
          state_d     = WAIT_HI;
        end
      end
      WAIT_HI: if (bus.tx_busy)  state_d = WAIT_LO;
      WAIT_LO: if (!bus.tx_busy) state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      cmd_code_q  <= '0;
      cmd_data_q  <= '0;
      cmd_valid_q <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_drop_q   <= 1'b0;
      for (int i = 0; i < QN; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      cmd_code_q  <= cmd_code_d;
      cmd_data_q  <= cmd_data_d;
      cmd_valid_q <= cmd_valid_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      rx_drop_q   <= rx_drop_d;
      buf_q       <= buf_d;
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_code  = cmd_code_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.rx_drop   = rx_drop_q;
endmodule

// File: tb/tb_uart_cmd_engine.sv
// Scoreboard bench: expected transmit bytes are queued as stimulus is driven
// and popped by a transmitter model whenever the engine issues tx_start.
module tb_uart_cmd_engine;
  localparam int DW   = 32;
  localparam int RW   = 32;
  localparam int TO   = 20;
  localparam int BUSY = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_engine_if #(.DATA_W(DW), .RESP_W(RW)) bus ();
  uart_cmd_engine #(.DATA_W(DW), .RESP_W(RW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tx_n = 0;
  int tx_cyc [256];
  int valid_seen = 0;
  int t_rx = 0;
  int t_done = 0;
  int n0 = 0;
  int hi_cnt = 0;
  logic [7:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.cmd_valid === 1'b1) valid_seen <= valid_seen + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Transmitter model: takes the byte, then holds busy for BUSY cycles.
  initial begin
    logic [7:0] e;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (tx_n < 256) tx_cyc[tx_n] = cyc;
        tx_n++;
        if (exp_q.size() == 0) begin
          chk("tx_unexpected_byte", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", bus.tx_data, e);
        end
        bus.tx_busy = 1'b1;
        repeat (BUSY) @(negedge clk);
        bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input bit echo);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t_rx = cyc;
    if (echo) exp_q.push_back(b);
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.tx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", (n >= 2000), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_echoed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_rx(s[i], 1'b1);
      wait_idle();
    end
  endtask

  task automatic push_resp(input logic [RW-1:0] d, input int len);
    int l;
    logic [3:0] n;
    l = (len > RW/4) ? RW/4 : len;
    exp_q.push_back(8'h2B);
    for (int i = l - 1; i >= 0; i--) begin
      n = d[4*i +: 4];
      exp_q.push_back((n < 4'd10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10));
    end
  endtask

  task automatic pulse_done(input logic [RW-1:0] d, input int len);
    bus.cmd_done  = 1'b1;
    bus.resp_data = d;
    bus.resp_len  = 4'(len);
    push_resp(d, len);
    t_done = cyc;
    n0 = tx_n;
    @(negedge clk);
    bus.cmd_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data   = '0;
    bus.rx_valid  = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.resp_data = '0;
    bus.resp_len  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_cmd_valid", bus.cmd_valid, 0);
    chk("rst_cmd_code", bus.cmd_code, 0);
    chk("rst_cmd_data", bus.cmd_data, 0);
    chk("rst_rx_drop", bus.rx_drop, 0);
    reset = 1'b0;

    // $L12aF+ -> +beef
    n0 = tx_n;
    send_echoed("$");
    chk("echo_latency", tx_cyc[n0] - t_rx, 2);
    send_echoed("L12aF");
    send_rx(8'h2B, 1'b0);
    chk("L_valid", bus.cmd_valid, 1);
    chk("L_code", bus.cmd_code, 8'h4C);
    chk("L_data", bus.cmd_data, 32'h0000_12AF);
    @(negedge clk);
    chk("L_valid_held", bus.cmd_valid, 1);
    pulse_done(32'h0000_BEEF, 4);
    chk("L_valid_low", bus.cmd_valid, 0);
    chk("L_code_clr", bus.cmd_code, 0);
    chk("L_data_clr", bus.cmd_data, 0);
    wait_idle();
    chk("done_latency", tx_cyc[n0] - t_done, 2);

    // $G+ with resp_len=0 -> "+"
    send_echoed("$G");
    send_rx(8'h2B, 1'b0);
    chk("G_valid", bus.cmd_valid, 1);
    chk("G_code", bus.cmd_code, 8'h47);
    chk("G_data", bus.cmd_data, 0);
    pulse_done(32'h1234_5678, 0);
    wait_idle();

    // Nine digits keep the last eight; oversized resp_len clamps to 8 digits
    send_echoed("$Q123456789");
    send_rx(8'h2B, 1'b0);
    chk("Q_data", bus.cmd_data, 32'h2345_6789);
    pulse_done(32'h89AB_CDEF, 15);
    wait_idle();

    // Lowercase command letter -> +ERR without dispatch
    send_echoed("$s");
    valid_seen = 0;
    exp_q.push_back(8'h2B); exp_q.push_back(8'h45);
    exp_q.push_back(8'h52); exp_q.push_back(8'h52);
    send_rx(8'h2B, 1'b0);
    wait_idle();
    chk("s_valid_never", valid_seen, 0);

    // No done -> cmd_valid for exactly TIMEOUT cycles, then +TO
    send_echoed("$X");
    exp_q.push_back(8'h2B); exp_q.push_back(8'h54); exp_q.push_back(8'h4F);
    send_rx(8'h2B, 1'b0);
    hi_cnt = 0;
    while (bus.cmd_valid === 1'b1 && hi_cnt < 100) begin
      hi_cnt++;
      @(negedge clk);
    end
    chk("to_valid_cycles", hi_cnt, TO);
    wait_idle();

    // Done on the expiry cycle wins over timeout
    send_echoed("$X");
    send_rx(8'h2B, 1'b0);
    repeat (TO - 1) @(negedge clk);
    chk("race_valid", bus.cmd_valid, 1);
    pulse_done(32'h0000_005A, 2);
    chk("race_valid_low", bus.cmd_valid, 0);
    wait_idle();

    // Byte during WAIT_LO is dropped and flagged; "$" clears the flag
    send_rx(8'h24, 1'b1);
    repeat (2) @(negedge clk);
    send_rx(8'h4B, 1'b0);
    chk("drop_flag", bus.rx_drop, 1);
    wait_idle();
    chk("drop_sticky", bus.rx_drop, 1);
    chk("drop_no_code", bus.cmd_code, 0);
    send_echoed("$");
    chk("drop_cleared", bus.rx_drop, 0);

    // Async reset in EXEC
    send_echoed("R");
    send_rx(8'h2B, 1'b0);
    chk("R_valid", bus.cmd_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cmd_valid", bus.cmd_valid, 0);
    chk("arst_tx_start", bus.tx_start, 0);
    chk("arst_cmd_code", bus.cmd_code, 0);
    @(negedge clk);
    reset = 1'b0;

    // Recovery after reset
    send_echoed("$A");
    send_rx(8'h2B, 1'b0);
    chk("A_code", bus.cmd_code, 8'h41);
    pulse_done(32'h0000_0007, 1);
    wait_idle();

    repeat (50) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    chk("final_rx_drop", bus.rx_drop, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
Parametrised successor to the top-level serial command loop. It parses an ASCII command stream of the form "$", a command letter, hex digits, then "+" from a byte-wide UART receiver. It dispatches each command to a downstream unit through a valid/done handshake and returns the result as "+" followed by hex ASCII through a byte-wide UART transmitter. Compared with the hand-coded loop, it adds generic data and response widths, a done timeout, command-letter validation and an rx-overrun flag.

Parameters:
DATA_W, 32, command argument width in bits; multiple of 4; 4..64
RESP_W, 32, response data width in bits; multiple of 4; 4..64
TIMEOUT, 5000000, clk cycles to wait for cmd_done before aborting; must be ≥1

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  1-cycle strobe; rx_data is valid in that cycle
tx_data  out  8  byte to transmit
tx_start  out  1  1-cycle request to the transmitter
tx_busy  in  1  transmitter busy
cmd_valid  out  1  command pending; held high until done or timeout
cmd_code  out  8  command letter
cmd_data  out  DATA_W  parsed argument
cmd_done  in  1  1-cycle completion strobe
resp_data  in  RESP_W  result; sampled on cmd_done
resp_len  in  clog2(RESP_W/4+1)  number of hex digits to return; sampled on cmd_done
rx_drop  out  1  sticky; a byte arrived while not in IDLE; cleared only by reset or "$"

Behaviour:
- Reset (async):
  - state=IDLE; all outputs 0; cmd_code=0; cmd_data=0; internal send buffer and counters cleared.
- States: IDLE, EXEC, SEND, WAIT_HI, WAIT_LO.
- IDLE, rx_valid with "$" (0x24):
  - cmd_code<=0, cmd_data<=0, rx_drop<=0.
  - Queue echo "$" (1 char), go to SEND.
- IDLE, rx_valid with other byte ≠ "+":
  - Queue an echo of that byte.
  - If cmd_code==0, cmd_code<=byte.
  - Otherwise cmd_data<={cmd_data[DATA_W-5:0], nib}.
    - nib: "0"-"9" → 0-9; "a"-"f" / "A"-"F" → 10-15; anything else → 0.
    - Extra digits shift the oldest digits out; no error is raised.
- IDLE, rx_valid with "+" (not echoed):
  - If cmd_code is in "A".."Z": cmd_valid<=1, timer<=TIMEOUT, go to EXEC.
  - Otherwise queue "+ERR", go to SEND.
- EXEC:
  - cmd_code and cmd_data are held stable while cmd_valid=1.
  - cmd_done=1: cmd_valid<=0 in the same edge; latch resp_data and resp_len.
    - Queue "+" followed by resp_len hex digits of resp_data, taken from the least-significant resp_len nibbles, MSB first.
    - Hex digits are lowercase: 0-9 → 0x30+n, 10-15 → 0x57+n.
    - resp_len=0 sends "+" only. resp_len > RESP_W/4 is clamped to RESP_W/4.
  - timer reaches 0 without done: cmd_valid<=0; queue "+TO".
  - cmd_done in the same cycle the timer expires: done wins.
  - After either exit, cmd_code<=0 and cmd_data<=0 so a new "$" is not required.
- SEND:
  - Queue empty → IDLE.
  - Otherwise wait for tx_busy=0, then drive tx_data=head byte and tx_start=1 for one cycle; pop; go to WAIT_HI.
- WAIT_HI: wait for tx_busy=1 → WAIT_LO. There is no timeout; the transmitter must assert busy.
- WAIT_LO: wait for tx_busy=0 → SEND.
- Send queue: shift buffer of 4+RESP_W/4 bytes, with a byte count.
- rx_valid in any state other than IDLE: byte discarded, rx_drop<=1.
- Latencies:
  - rx_valid at edge N → tx_start at edge N+2 if tx_busy=0.
  - cmd_done at N → first tx_start at N+2.
- Reset mid-command or mid-send:
  - Immediate abort; cmd_valid drops asynchronously.
  - A partially sent response is not resumed.

Test Plan:
- Reset, then bytes "$","L","1","2","a","F","+" with cmd_done two cycles later, resp_data=0x0000BEEF, resp_len=4 → echo "$L12aF"; cmd_valid high with cmd_code=0x4C, cmd_data=0x000012AF; tx sequence "+beef"; cmd_valid low after done.
- "$","G","+" with cmd_done, resp_len=0 → echo "$G", then tx "+" only; cmd_data=0.
- Nine hex digits "123456789" with DATA_W=32 → cmd_data=0x23456789.
- "$","s","+" (lowercase letter) → tx "+ERR"; cmd_valid never asserts.
- TIMEOUT=20, "$","X","+" with no cmd_done → cmd_valid high exactly 20 cycles, then tx "+TO". Repeat with cmd_done at cycle 20 → response sent, no "+TO".
- rx_valid strobed during WAIT_LO → byte ignored, rx_drop=1. A following "$" clears rx_drop. Async reset during EXEC → cmd_valid=0 and tx_start=0 immediately.
